// File: rtl/elm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elm_pkg: shared widths, saturation limits and FSM encoding for ELM MAC.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package elm_pkg;

  localparam int IN_W_DEF  = 24;
  localparam int ACC_W_DEF = 32;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/elm_sat_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elm_sat_add: sign-extending adder with overflow flag and optional clamp.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module elm_sat_add
  import elm_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SAT   = 1
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] full_w;

  // One guard bit: sum is out of range exactly when the top two bits differ.
  assign full_w = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-IN_W){add_i[IN_W-1]}}, add_i};
  assign ovf_o  = full_w[ACC_W] ^ full_w[ACC_W-1];

  always_comb begin
    sum_o = full_w[ACC_W-1:0];
    if ((SAT != 0) && ovf_o) begin
      sum_o = full_w[ACC_W] ? C_MIN : C_MAX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/elm_acc_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elm_acc_bank: NCH-channel frame accumulator with valid/ready result reg.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module elm_acc_bank
  import elm_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int IN_W    = IN_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = 256,
  parameter int SAT     = 1,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [NCH*IN_W-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*ACC_W-1:0]   out_data,
  output logic [NCH-1:0]         out_ovf,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_trunc
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc_w;
  logic [NCH*ACC_W-1:0] acc_q, acc_d, sum_w;
  logic [NCH-1:0]       ovf_q, ovf_d, ovf_w;
  logic                 beat_w, at_max_w, end_w;

  logic                 out_valid_q;
  logic [NCH*ACC_W-1:0] out_data_q;
  logic [NCH-1:0]       out_ovf_q;
  logic [CNT_W-1:0]     out_count_q;
  logic                 out_trunc_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    elm_sat_add #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .SAT   (SAT)
    ) u_add (
      .acc_i (acc_q[c*ACC_W +: ACC_W]),
      .add_i (in_data[c*IN_W +: IN_W]),
      .sum_o (sum_w[c*ACC_W +: ACC_W]),
      .ovf_o (ovf_w[c])
    );
  end

  assign in_ready  = !rst && !clr && (!out_valid_q || out_ready);
  assign beat_w    = in_valid && in_ready;
  assign cnt_inc_w = cnt_q + CNT_W'(1);
  assign at_max_w  = (cnt_q == CNT_W'(MAX_LEN - 1));
  assign end_w     = beat_w && (in_last || at_max_w);

  // A frame end clears the bank on the same edge the result is captured.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clr || end_w) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = '0;
    end else if (beat_w) begin
      state_d = ST_RUN;
      cnt_d   = cnt_inc_w;
      acc_d   = sum_w;
      ovf_d   = ovf_q | ovf_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
    end else if (end_w) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sum_w;
      out_ovf_q   <= ovf_q | ovf_w;
      out_count_q <= cnt_inc_w;
      out_trunc_q <= !in_last;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_elm_acc_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_elm_acc_bank: directed self-checking bench for elm_acc_bank.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_elm_acc_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Four-channel bank, MAX_LEN=4, saturating
  logic         a_clr = 0, a_valid = 0, a_last = 0, a_oready = 0;
  logic [95:0]  a_data = '0;
  logic         a_iready, a_ovalid, a_trunc;
  logic [127:0] a_odata;
  logic [3:0]   a_ovf;
  logic [2:0]   a_count;

  // Single-channel pair, MAX_LEN=512, saturating vs wrapping, shared inputs
  logic         s_valid = 0, s_last = 0;
  logic [23:0]  s_data = '0;
  logic         s_iready, s_ovalid, s_trunc, w_iready, w_ovalid, w_trunc;
  logic [31:0]  s_odata, w_odata;
  logic [0:0]   s_ovf, w_ovf;
  logic [9:0]   s_count, w_count;

  elm_acc_bank #(.NCH(4), .IN_W(24), .ACC_W(32), .MAX_LEN(4), .SAT(1)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_valid), .in_ready(a_iready),
    .in_last(a_last), .in_data(a_data), .out_valid(a_ovalid), .out_ready(a_oready),
    .out_data(a_odata), .out_ovf(a_ovf), .out_count(a_count), .out_trunc(a_trunc));

  elm_acc_bank #(.NCH(1), .IN_W(24), .ACC_W(32), .MAX_LEN(512), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .clr(1'b0), .in_valid(s_valid), .in_ready(s_iready),
    .in_last(s_last), .in_data(s_data), .out_valid(s_ovalid), .out_ready(1'b1),
    .out_data(s_odata), .out_ovf(s_ovf), .out_count(s_count), .out_trunc(s_trunc));

  elm_acc_bank #(.NCH(1), .IN_W(24), .ACC_W(32), .MAX_LEN(512), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .clr(1'b0), .in_valid(s_valid), .in_ready(w_iready),
    .in_last(s_last), .in_data(s_data), .out_valid(w_ovalid), .out_ready(1'b1),
    .out_data(w_odata), .out_ovf(w_ovf), .out_count(w_count), .out_trunc(w_trunc));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic v, input logic l, input int d0, input int d1,
                        input int d2, input int d3);
    a_valid = v;
    a_last  = l;
    a_data  = {24'(d3), 24'(d2), 24'(d1), 24'(d0)};
  endtask

  function automatic logic [127:0] pack4(input int d0, input int d1, input int d2, input int d3);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", a_iready, 0);
    chk("rst_out_valid", a_ovalid, 0);
    chk("rst_out_data", a_odata, 0);
    chk("rst_out_misc", {a_ovf, a_count, a_trunc}, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", a_iready, 1);

    // Partial frame, then reset mid-frame
    a_beat(1, 0, 5, 5, 5, 5);
    tick();
    a_beat(0, 0, 0, 0, 0, 0);
    rst = 1;
    tick();
    chk("midrst_in_ready", a_iready, 0);
    chk("midrst_out_valid", a_ovalid, 0);
    rst = 0;

    // Basic 3-beat frame
    a_beat(1, 0, 1, 2, -3, 100);
    tick();
    tick();
    chk("basic_valid_b2", a_ovalid, 0);
    a_last = 1;
    tick();
    a_beat(0, 0, 0, 0, 0, 0);
    chk("basic_valid", a_ovalid, 1);
    chk("basic_data", a_odata, pack4(3, 6, -9, 300));
    chk("basic_count", a_count, 3);
    chk("basic_ovf_trunc", {a_ovf, a_trunc}, 0);
    a_oready = 1;
    tick();
    chk("consume_valid", a_ovalid, 0);
    chk("consume_hold", a_odata, pack4(3, 6, -9, 300));

    // Backpressure
    a_oready = 0;
    a_beat(1, 1, 7, 0, 0, 0);
    tick();
    chk("bp_first_valid", a_ovalid, 1);
    a_beat(1, 1, 2, 3, 4, 5);
    #1;
    chk("bp_in_ready", a_iready, 0);
    tick();
    tick();
    chk("bp_held_data", a_odata, pack4(7, 0, 0, 0));
    a_oready = 1;
    #1;
    chk("bp_release_ready", a_iready, 1);
    tick();
    a_beat(0, 0, 0, 0, 0, 0);
    chk("bp_valid_stays", a_ovalid, 1);
    chk("bp_second_data", a_odata, pack4(2, 3, 4, 5));
    chk("bp_second_count", a_count, 1);
    tick();
    chk("bp_drain", a_ovalid, 0);

    // MAX_LEN truncation and restart
    a_beat(1, 0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("max_valid", a_ovalid, 1);
    chk("max_data", a_odata, pack4(4, 4, 4, 4));
    chk("max_count_trunc", {a_count, a_trunc}, {3'd4, 1'b1});
    tick();
    chk("max_b5_valid", a_ovalid, 0);
    a_last = 1;
    tick();
    chk("max_restart_data", a_odata, pack4(2, 2, 2, 2));
    chk("max_restart_cnt", {a_count, a_trunc}, {3'd2, 1'b0});
    a_last = 0;
    for (int i = 0; i < 3; i++) tick();
    a_last = 1;
    tick();
    chk("last_at_max", {a_count, a_trunc}, {3'd4, 1'b0});
    chk("last_at_max_data", a_odata, pack4(4, 4, 4, 4));

    // clr mid-frame drops the coincident beat and partial sums
    a_beat(1, 0, 1, 1, 1, 1);
    tick();
    a_clr = 1;
    a_beat(1, 0, 50, 50, 50, 50);
    #1;
    chk("clr_in_ready", a_iready, 0);
    tick();
    a_clr = 0;
    a_beat(1, 1, 4, 4, 4, 4);
    tick();
    chk("clr_fresh_data", a_odata, pack4(4, 4, 4, 4));
    chk("clr_fresh_count", a_count, 1);
    a_oready = 0;
    a_beat(0, 0, 0, 0, 0, 0);
    a_clr = 1;
    tick();
    a_clr = 0;
    chk("clr_pending_valid", a_ovalid, 1);
    chk("clr_pending_data", a_odata, pack4(4, 4, 4, 4));

    // Saturation vs wrap: 256*(2^23-1) + (256-2^23) = 2^31-2^23, then two more maxima
    s_valid = 1;
    s_data  = 24'h7FFFFF;
    for (int i = 0; i < 256; i++) tick();
    s_data = 24'(256 - 8388608);
    tick();
    s_data = 24'h7FFFFF;
    tick();
    s_last = 1;
    tick();
    s_valid = 0;
    s_last  = 0;
    chk("sat_valid", {s_ovalid, w_ovalid}, 2'b11);
    chk("sat_data", s_odata, 32'h7FFF_FFFF);
    chk("sat_ovf", s_ovf, 1);
    chk("sat_count", s_count, 259);
    chk("wrap_data", w_odata, 32'h807F_FFFE);
    chk("wrap_ovf", w_ovf, 1);
    s_valid = 1;
    s_last  = 1;
    s_data  = 24'd5;
    tick();
    s_valid = 0;
    s_last  = 0;
    chk("ovf_cleared", {s_ovf, w_ovf}, 0);
    chk("sat_next_data", s_odata, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
